// File: rtl/u712_chip_cycle_arbiter.sv
// Two-requester (CPU / PCI) arbiter for the chipset cycle engine: slot-aligned launch, round-robin after each cycle.
// Optional hung-cycle watchdog (bus error on expiry) enabled by defining CYCLE_TIMEOUT_EN.
module u712_chip_cycle_arbiter #(
  parameter int unsigned RR_INIT        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic CLK40,
  input  logic nRESET,
  input  logic C1,
  input  logic C3,
  input  logic CPU_REQ,
  input  logic CPU_RAM,
  input  logic CPU_RnW,
  input  logic PCI_REQ,
  input  logic PCI_RAM,
  input  logic PCI_RnW,
  input  logic ENG_TA,
  output logic ENG_START,
  output logic ENG_RAM,
  output logic ENG_RnW,
  output logic CPU_GNT,
  output logic PCI_GNT,
  output logic CPU_ACK,
  output logic PCI_ACK,
  output logic BUS_ERR
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SLOT_WAIT = 2'd1,
    S_ACTIVE    = 2'd2,
    S_RELEASE   = 2'd3
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PCI = 1'b1;

  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 16..65535");
  end

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;
  logic   eng_ram_q, eng_ram_d;
  logic   eng_rnw_q, eng_rnw_d;
  logic   cpu_gnt_q, cpu_gnt_d;
  logic   pci_gnt_q, pci_gnt_d;
  logic   eng_start_q, eng_start_d;
  logic   cpu_ack_q, cpu_ack_d;
  logic   pci_ack_q, pci_ack_d;

  logic owner_req;
  logic slot_open;
  logic timeout_hit;
  logic pick_pci;
  logic cycle_done;

  assign owner_req = (owner_q == OWNER_PCI) ? PCI_REQ : CPU_REQ;
  // The engine may only be launched in 68000 state 2, i.e. both phase clocks low.
  assign slot_open = !C1 && !C3;

`ifdef CYCLE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_err_q, bus_err_d;

  // tmo_cnt_q+1 is the index of the ACTIVE cycle being sampled on this edge.
  assign timeout_hit = (state_q == S_ACTIVE) && (tmo_cnt_q + 16'd1 == TIMEOUT_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SLOT_WAIT) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACTIVE) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  assign bus_err_d = cycle_done && !ENG_TA;

  always_ff @(negedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign BUS_ERR = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign BUS_ERR     = 1'b0;
`endif

  // State register: all state moves on the falling edge of CLK40.
  always_ff @(negedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      owner_q     <= OWNER_CPU;
      rr_q        <= 1'(RR_INIT);
      eng_ram_q   <= 1'b0;
      eng_rnw_q   <= 1'b1;
      cpu_gnt_q   <= 1'b0;
      pci_gnt_q   <= 1'b0;
      eng_start_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      pci_ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      eng_ram_q   <= eng_ram_d;
      eng_rnw_q   <= eng_rnw_d;
      cpu_gnt_q   <= cpu_gnt_d;
      pci_gnt_q   <= pci_gnt_d;
      eng_start_q <= eng_start_d;
      cpu_ack_q   <= cpu_ack_d;
      pci_ack_q   <= pci_ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    eng_ram_d = eng_ram_q;
    eng_rnw_d = eng_rnw_q;
    pick_pci  = PCI_REQ && (!CPU_REQ || rr_q);
    unique case (state_q)
      S_IDLE: begin
        if (CPU_REQ || PCI_REQ) begin
          owner_d   = pick_pci ? OWNER_PCI : OWNER_CPU;
          eng_ram_d = pick_pci ? PCI_RAM : CPU_RAM;
          eng_rnw_d = pick_pci ? PCI_RnW : CPU_RnW;
          state_d   = S_SLOT_WAIT;
        end
      end
      S_SLOT_WAIT: begin
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (slot_open) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // Owner REQ is deliberately ignored here: a launched cycle always completes.
        if (ENG_TA || timeout_hit) begin
          rr_d    = ~owner_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!owner_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    cycle_done  = (state_q == S_ACTIVE) && (state_d == S_RELEASE);
    cpu_gnt_d   = ((state_d == S_SLOT_WAIT) || (state_d == S_ACTIVE)) && (owner_d == OWNER_CPU);
    pci_gnt_d   = ((state_d == S_SLOT_WAIT) || (state_d == S_ACTIVE)) && (owner_d == OWNER_PCI);
    eng_start_d = (state_q == S_SLOT_WAIT) && (state_d == S_ACTIVE);
    cpu_ack_d   = cycle_done && (owner_q == OWNER_CPU);
    pci_ack_d   = cycle_done && (owner_q == OWNER_PCI);
  end

  assign ENG_START = eng_start_q;
  assign ENG_RAM   = eng_ram_q;
  assign ENG_RnW   = eng_rnw_q;
  assign CPU_GNT   = cpu_gnt_q;
  assign PCI_GNT   = pci_gnt_q;
  assign CPU_ACK   = cpu_ack_q;
  assign PCI_ACK   = pci_ack_q;

endmodule

// File: tb/tb_u712_chip_cycle_arbiter.sv
// Directed bench for u712_chip_cycle_arbiter; outputs are sampled on the rising edge, between active falling edges.
// Output vector order: {ENG_START, ENG_RAM, ENG_RnW, CPU_GNT, PCI_GNT, CPU_ACK, PCI_ACK, BUS_ERR}.
module tb_u712_chip_cycle_arbiter;

  logic CLK40 = 1'b1;
  logic nRESET, C1, C3;
  logic CPU_REQ, CPU_RAM, CPU_RnW, PCI_REQ, PCI_RAM, PCI_RnW, ENG_TA;
  logic ENG_START, ENG_RAM, ENG_RnW, CPU_GNT, PCI_GNT, CPU_ACK, PCI_ACK, BUS_ERR;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 CLK40 = ~CLK40;

  assign outs = {ENG_START, ENG_RAM, ENG_RnW, CPU_GNT, PCI_GNT, CPU_ACK, PCI_ACK, BUS_ERR};

  u712_chip_cycle_arbiter #(
    .RR_INIT        (0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK40     (CLK40),
    .nRESET    (nRESET),
    .C1        (C1),
    .C3        (C3),
    .CPU_REQ   (CPU_REQ),
    .CPU_RAM   (CPU_RAM),
    .CPU_RnW   (CPU_RnW),
    .PCI_REQ   (PCI_REQ),
    .PCI_RAM   (PCI_RAM),
    .PCI_RnW   (PCI_RnW),
    .ENG_TA    (ENG_TA),
    .ENG_START (ENG_START),
    .ENG_RAM   (ENG_RAM),
    .ENG_RnW   (ENG_RnW),
    .CPU_GNT   (CPU_GNT),
    .PCI_GNT   (PCI_GNT),
    .CPU_ACK   (CPU_ACK),
    .PCI_ACK   (PCI_ACK),
    .BUS_ERR   (BUS_ERR)
  );

  task automatic check(input string tag, input logic [7:0] expected);
    checks++;
    assert (outs === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, expected);
    end
  endtask

  // One active falling edge, then return on the following rising edge.
  task automatic cyc();
    @(negedge CLK40);
    @(posedge CLK40);
  endtask

  task automatic slot(input logic open);
    C1 = !open;
    C3 = !open;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    nRESET = 1'b0; C1 = 1'b1; C3 = 1'b1; ENG_TA = 1'b0;
    CPU_REQ = 1'b0; CPU_RAM = 1'b0; CPU_RnW = 1'b1;
    PCI_REQ = 1'b0; PCI_RAM = 1'b0; PCI_RnW = 1'b1;
    @(posedge CLK40);
    check("reset_values", 8'b0010_0000);
    nRESET = 1'b1;
    cyc();
    check("idle_after_reset", 8'b0010_0000);

    ENG_TA = 1'b1;
    cyc();
    check("ta_ignored_idle", 8'b0010_0000);
    ENG_TA = 1'b0;

    // Contention with pointer at CPU.
    CPU_REQ = 1'b1; CPU_RAM = 1'b1; CPU_RnW = 1'b0;
    PCI_REQ = 1'b1; PCI_RAM = 1'b0; PCI_RnW = 1'b1;
    cyc();
    check("both_req_cpu_gnt", 8'b0101_0000);
    slot(1'b1);
    cyc();
    check("cpu_start", 8'b1101_0000);
    slot(1'b0);
    cyc();
    check("cpu_active", 8'b0101_0000);
    ENG_TA = 1'b1;
    cyc();
    check("cpu_ack", 8'b0100_0100);
    ENG_TA = 1'b0; CPU_REQ = 1'b0;
    cyc();
    check("cpu_release_to_idle", 8'b0100_0000);
    cyc();
    check("pci_gnt_after_cpu", 8'b0010_1000);
    slot(1'b1);
    cyc();
    check("pci_start", 8'b1010_1000);
    slot(1'b0);
    cyc();
    check("pci_active", 8'b0010_1000);
    ENG_TA = 1'b1;
    cyc();
    check("pci_ack", 8'b0010_0010);
    ENG_TA = 1'b0; PCI_REQ = 1'b0;
    cyc();
    check("pci_release_to_idle", 8'b0010_0000);

    CPU_REQ = 1'b1; CPU_RAM = 1'b0; CPU_RnW = 1'b1;
    PCI_REQ = 1'b1; PCI_RAM = 1'b1; PCI_RnW = 1'b0;
    cyc();
    check("rr_back_to_cpu", 8'b0011_0000);
    CPU_REQ = 1'b0; PCI_REQ = 1'b0;
    cyc();
    check("cpu_withdraw", 8'b0010_0000);

    // PCI withdrawal in SLOT_WAIT with the slot open: no launch, pointer stays at CPU.
    PCI_REQ = 1'b1;
    cyc();
    check("pci_only_gnt", 8'b0100_1000);
    PCI_REQ = 1'b0;
    slot(1'b1);
    cyc();
    check("pci_withdraw_no_start", 8'b0100_0000);
    slot(1'b0);
    CPU_REQ = 1'b1; PCI_REQ = 1'b1;
    cyc();
    check("pointer_unchanged", 8'b0011_0000);
    CPU_REQ = 1'b0; PCI_REQ = 1'b0;
    cyc();
    check("idle_again", 8'b0010_0000);

    // Slot alignment, TA ignored in SLOT_WAIT.
    CPU_REQ = 1'b1; CPU_RAM = 1'b0; CPU_RnW = 1'b1;
    cyc();
    check("slot_gnt", 8'b0011_0000);
    ENG_TA = 1'b1;
    cyc();
    check("slot_hold_ta_ignored", 8'b0011_0000);
    ENG_TA = 1'b0;
    slot(1'b1);
    cyc();
    check("slot_start", 8'b1011_0000);
    slot(1'b0);
    cyc();
    check("slot_active_1", 8'b0011_0000);
`ifdef CYCLE_TIMEOUT_EN
    for (int i = 0; i < 14; i++) cyc();
    check("active_15", 8'b0011_0000);
    cyc();
    check("timeout_bus_err", 8'b0010_0101);
`else
    for (int i = 0; i < 30; i++) cyc();
    check("no_timeout_wait", 8'b0011_0000);
    ENG_TA = 1'b1;
    cyc();
    check("late_ta_ack", 8'b0010_0100);
    ENG_TA = 1'b0;
`endif

    // Stale request: CPU_REQ stays high after the ack, even with the slot open.
    slot(1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("stale_release_%0d", i), 8'b0010_0000);
    end
    slot(1'b0);
    CPU_REQ = 1'b0;
    cyc();
    check("stale_drop_idle", 8'b0010_0000);

    // TA on the exact expiry edge wins over the watchdog.
    CPU_REQ = 1'b1;
    cyc();
    check("race_gnt", 8'b0011_0000);
    slot(1'b1);
    cyc();
    check("race_start", 8'b1011_0000);
    slot(1'b0);
    for (int i = 0; i < 15; i++) cyc();
    check("race_active_15", 8'b0011_0000);
    ENG_TA = 1'b1;
    cyc();
    check("race_ta_wins", 8'b0010_0100);
    ENG_TA = 1'b0; CPU_REQ = 1'b0;
    cyc();
    check("race_idle", 8'b0010_0000);

    // Asynchronous reset in the middle of an ACTIVE cycle.
    CPU_REQ = 1'b1; CPU_RAM = 1'b1; CPU_RnW = 1'b0;
    cyc();
    check("rst_gnt", 8'b0101_0000);
    slot(1'b1);
    cyc();
    check("rst_start", 8'b1101_0000);
    slot(1'b0);
    cyc();
    check("rst_active", 8'b0101_0000);
    #2 nRESET = 1'b0;
    #1 check("async_reset", 8'b0010_0000);
    CPU_REQ = 1'b0;
    @(posedge CLK40);
    nRESET = 1'b1;
    PCI_REQ = 1'b1; PCI_RAM = 1'b1; PCI_RnW = 1'b1;
    cyc();
    check("post_reset_pci_gnt", 8'b0110_1000);
    PCI_REQ = 1'b0;
    cyc();
    check("post_reset_withdraw", 8'b0110_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/u712_chip_cycle_arbiter.md
Name: u712_chip_cycle_arbiter

Overview:
- Shares the chipset register/chip-RAM cycle engine between two requesters: the 68040 CPU and the PCI bridge master.
- Decides which requester owns the engine and latches that requester's cycle attributes (RAM/register space, direction).
- Launches the engine only in the C1=0/C3=0 slot (68000 state 2 equivalent), then returns the engine's transfer acknowledge to the owner.
- Round-robin fairness after every completed cycle; optional watchdog converts a hung cycle (e.g. _DBR held forever) into a bus error.

Parameters:
- RR_INIT, 0, round-robin pointer reset value. 0 means CPU preferred, 1 means PCI preferred.
- TIMEOUT_CYCLES, 1023, CLK40 cycles allowed in ACTIVE before abort. Used only with the optional feature. Range 16..65535.

Ports:
- CLK40  in  1  system clock; all state updates on falling edge.
- nRESET  in  1  asynchronous active-low reset.
- C1  in  1  Amiga phase clock C1.
- C3  in  1  Amiga phase clock C3.
- CPU_REQ  in  1  CPU chipset cycle request (decoded TIP and space); level, held until ack.
- CPU_RAM  in  1  1 = chip-RAM space, 0 = register space.
- CPU_RnW  in  1  CPU direction, 1 = read.
- PCI_REQ  in  1  PCI master chipset cycle request; level, held until ack.
- PCI_RAM  in  1  PCI space select, same encoding as CPU_RAM.
- PCI_RnW  in  1  PCI direction.
- ENG_TA  in  1  cycle engine transfer acknowledge; one-cycle pulse.
- ENG_START  out  1  one-cycle engine launch pulse.
- ENG_RAM  out  1  latched space for the engine.
- ENG_RnW  out  1  latched direction for the engine.
- CPU_GNT  out  1  CPU owns the engine.
- PCI_GNT  out  1  PCI owns the engine.
- CPU_ACK  out  1  one-cycle completion pulse to CPU.
- PCI_ACK  out  1  one-cycle completion pulse to PCI.
- BUS_ERR  out  1  one-cycle abort pulse, coincident with the owner's ACK.

Behaviour:
- Reset values: all outputs 0 except ENG_RnW=1; state IDLE; pointer=RR_INIT; timeout counter 0. Reset is asynchronous and may occur in any state. The first falling edge after release samples in IDLE.
- C1, C3, CPU_REQ and PCI_REQ are sampled on each falling CLK40 edge. Registered outputs change on that same edge.
- IDLE:
  - Only CPU_REQ: CPU wins.
  - Only PCI_REQ: PCI wins.
  - Both: pointer=0 gives CPU, pointer=1 gives PCI.
  - Winner: latch its RAM/RnW into ENG_RAM/ENG_RnW, assert its GNT, go to SLOT_WAIT.
- SLOT_WAIT:
  - Owner REQ low: drop GNT, back to IDLE. No start is issued; pointer unchanged.
  - Else C1=0 and C3=0: ENG_START=1 for exactly one cycle, go to ACTIVE. Timeout counter clears.
  - Otherwise hold.
- ACTIVE:
  - Owner REQ is ignored; a started cycle always completes.
  - ENG_TA=1: owner ACK=1 for one cycle, pointer set to the non-owner, go to RELEASE.
  - The second requester is never started while ACTIVE.
- RELEASE:
  - GNT drops on entry.
  - Stay in RELEASE while the last owner's REQ is high, so a stale request is not re-granted.
  - Go to IDLE once that REQ is low. Minimum one cycle.
- Back-to-back: after a CPU cycle with PCI_REQ pending, PCI is granted in IDLE and waits for the next C1=0/C3=0 slot. There is never more than one ENG_START per engine cycle.
- Exactly one GNT is high at a time. ENG_START is only ever issued with a GNT high.
- ENG_TA outside ACTIVE is ignored.

Optional Feature:
- Macro CYCLE_TIMEOUT_EN.
- Defined:
  - 16-bit counter increments each cycle in ACTIVE.
  - When it reaches TIMEOUT_CYCLES without ENG_TA: owner ACK=1 and BUS_ERR=1 for one cycle, pointer flips, go to RELEASE.
  - ENG_TA on the same edge as expiry: TA wins, BUS_ERR stays 0.
- Undefined: no counter; BUS_ERR tied 0; ACTIVE waits for ENG_TA indefinitely.

Test Plan:
- Reset: pulse nRESET low mid-ACTIVE with CPU_GNT=1 -> all outputs 0 (ENG_RnW=1) immediately, asynchronously; after release, PCI_REQ alone -> PCI_GNT next falling edge.
- Slot alignment: CPU_REQ=1, CPU_RAM=0, CPU_RnW=1 with C1=1, C3=1 -> CPU_GNT=1, no ENG_START until the first edge sampling C1=0/C3=0; then a single pulse with ENG_RAM=0, ENG_RnW=1.
- Contention with RR_INIT=0: CPU_REQ and PCI_REQ raised together -> CPU served first, ENG_TA -> CPU_ACK; CPU_REQ drops -> PCI_GNT, next slot -> ENG_START; order CPU then PCI, and a new simultaneous request then grants CPU again.
- Withdrawal: PCI_REQ raised then dropped in SLOT_WAIT -> PCI_GNT falls, no ENG_START, pointer unchanged.
- Timeout (CYCLE_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold ENG_TA=0 -> BUS_ERR and CPU_ACK high together on the 16th ACTIVE cycle; with ENG_TA applied on that exact edge -> CPU_ACK=1, BUS_ERR=0.
- Stale request: CPU keeps CPU_REQ high for 5 cycles after CPU_ACK -> remains in RELEASE, no re-grant, no second ENG_START.
